// File: rtl/ot_transmitter_fifo.sv
// UART transmitter fed by a small TX FIFO; parity and stop bits configurable.
// Ports: clk_50m/rstn, clken baud tick, data_in/wr_en write side,
// full/empty/level/overflow FIFO status, Tx serial line, Tx_busy.
module ot_transmitter_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk_50m,
  input  logic                               rstn,
  input  logic                               clken,
  input  logic [DATA_BITS-1:0]               data_in,
  input  logic                               wr_en,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level,
  output logic                               overflow,
  output logic                               Tx,
  output logic                               Tx_busy
);

  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [LW-1:0] DEPTH     = LW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS-1);
  localparam logic          LAST_STOP = 1'(STOP_BITS-1);
  localparam logic          ODD       = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 push;
  logic                 pop;

  state_t               state;
  state_t               state_d;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_d;
  logic [BW-1:0]        bit_pos;
  logic [BW-1:0]        bit_pos_d;
  logic                 stop_cnt;
  logic                 stop_cnt_d;
  logic                 tx_d;
  logic                 par_q;

  assign full    = (level == DEPTH);
  assign empty   = (level == '0);
  assign push    = wr_en & ~full;
  // Pop only from IDLE, so the word in the shift register is never touched
  // by FIFO traffic while a frame is on the line.
  assign pop     = (state == S_IDLE) & ~empty;
  assign Tx_busy = (state != S_IDLE);

  always_ff @(posedge clk_50m) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50m) begin
    if (!rstn) begin
      state    <= S_IDLE;
      shreg    <= '0;
      bit_pos  <= '0;
      stop_cnt <= 1'b0;
      Tx       <= 1'b1;
      par_q    <= 1'b0;
    end else begin
      state    <= state_d;
      shreg    <= shreg_d;
      bit_pos  <= bit_pos_d;
      stop_cnt <= stop_cnt_d;
      Tx       <= tx_d;
      if (pop) begin
        par_q <= ^mem[rd_ptr] ^ ODD;
      end
    end
  end

  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    bit_pos_d  = bit_pos;
    stop_cnt_d = stop_cnt;
    tx_d       = Tx;
    unique case (state)
      S_IDLE: begin
        if (pop) begin
          shreg_d = mem[rd_ptr];
          state_d = S_START;
        end
      end
      S_START: begin
        if (clken) begin
          tx_d      = 1'b0;
          bit_pos_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (clken) begin
          // LSB first: shifting right keeps the next bit at index 0.
          tx_d    = shreg[0];
          shreg_d = shreg >> 1;
          if (bit_pos == LAST_BIT) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_pos_d = bit_pos + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (clken) begin
          tx_d    = par_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (clken) begin
          tx_d = 1'b1;
          if (stop_cnt == LAST_STOP) begin
            stop_cnt_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ot_transmitter_fifo.sv
// Scoreboard bench for ot_transmitter_fifo: four parameterisations,
// expected frames queued at stimulus time, per-DUT line monitors compare.
module tb_ot_transmitter_fifo;

  logic clk_50m = 1'b0;
  always #10 clk_50m = ~clk_50m;

  logic       rstn;
  logic       clken;
  logic [7:0] din [3];
  logic [4:0] din5;
  logic       wr    [4];
  logic       tx    [4];
  logic       busy  [4];
  logic       full  [4];
  logic       empty [4];
  logic       ovf   [4];
  logic [2:0] lvl   [4];

  ot_transmitter_fifo u0 (
    .clk_50m(clk_50m), .rstn(rstn), .clken(clken),
    .data_in(din[0]), .wr_en(wr[0]), .full(full[0]),
    .empty(empty[0]), .level(lvl[0]), .overflow(ovf[0]),
    .Tx(tx[0]), .Tx_busy(busy[0])
  );

  ot_transmitter_fifo #(.PARITY_EN(1), .STOP_BITS(2)) u1 (
    .clk_50m(clk_50m), .rstn(rstn), .clken(clken),
    .data_in(din[1]), .wr_en(wr[1]), .full(full[1]),
    .empty(empty[1]), .level(lvl[1]), .overflow(ovf[1]),
    .Tx(tx[1]), .Tx_busy(busy[1])
  );

  ot_transmitter_fifo #(
    .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
  ) u2 (
    .clk_50m(clk_50m), .rstn(rstn), .clken(clken),
    .data_in(din[2]), .wr_en(wr[2]), .full(full[2]),
    .empty(empty[2]), .level(lvl[2]), .overflow(ovf[2]),
    .Tx(tx[2]), .Tx_busy(busy[2])
  );

  ot_transmitter_fifo #(.DATA_BITS(5)) u3 (
    .clk_50m(clk_50m), .rstn(rstn), .clken(clken),
    .data_in(din5), .wr_en(wr[3]), .full(full[3]),
    .empty(empty[3]), .level(lvl[3]), .overflow(ovf[3]),
    .Tx(tx[3]), .Tx_busy(busy[3])
  );

  typedef struct {
    int          id;
    int          len;
    logic [15:0] bits;
    bit          b2b;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;
  int   tick_no = 0;
  logic tick_seen = 1'b0;
  logic rst_seen = 1'b0;
  bit   tick_en = 1'b0;

  always @(posedge clk_50m) begin
    tick_seen <= clken;
    rst_seen  <= !rstn;
    if (clken) tick_no <= tick_no + 1;
  end

  initial begin
    int div;
    div = 0;
    clken = 1'b0;
    forever begin
      @(negedge clk_50m);
      if (tick_en && div == 15) begin
        clken = 1'b1;
        div = 0;
      end else begin
        clken = 1'b0;
        if (tick_en) div++;
      end
    end
  end

  function automatic int flen(int g);
    case (g)
      0:       return 10;
      1, 2:    return 12;
      default: return 7;
    endcase
  endfunction

  task automatic check_frame(int g, logic [15:0] cap, int st, int le);
    exp_t e;
    nvec++;
    if (q.size() == 0) begin
      nerr++;
      $display("FAIL frame_unexpected dut%0d: got %b required none",
               g, cap);
    end else begin
      e = q.pop_front();
      if (e.id != g || cap !== e.bits || (e.b2b && st != le + 1)) begin
        nerr++;
        $display("FAIL frame dut%0d: got %b start %0d, required dut%0d %b b2b=%0d prev_end %0d",
                 g, cap, st, e.id, e.bits, e.b2b, le);
      end
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_mon
    bit          act = 1'b0;
    int          nb = 0;
    logic [15:0] cap = '0;
    int          st = 0;
    int          last_end = -100;
    always @(negedge clk_50m) begin
      if (rst_seen) begin
        act = 1'b0;
      end else if (tick_seen) begin
        if (!act) begin
          if (tx[g] == 1'b0) begin
            act = 1'b1;
            cap = '0;
            nb  = 1;
            st  = tick_no;
          end
        end else begin
          cap = {cap[14:0], tx[g]};
          nb++;
        end
        if (act && nb == flen(g)) begin
          act = 1'b0;
          check_frame(g, cap, st, last_end);
          last_end = tick_no;
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic wrw(int id, logic [7:0] d);
    if (id == 3) din5 = d[4:0];
    else din[id] = d;
    wr[id] = 1'b1;
    @(negedge clk_50m);
    wr[id] = 1'b0;
  endtask

  task automatic expect_frame(int id, int len, logic [15:0] b, bit bb);
    exp_t e;
    e = '{id, len, b, bb};
    q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 4000) begin
      @(negedge clk_50m);
      n++;
    end
    nvec++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d frames outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk_50m);
      n++;
    end while (!tick_seen && n < 100);
    if (!tick_seen) chk("wait_tick", 0, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time exhausted, required finish");
    $fatal(1);
  end

  initial begin
    int lv [5];
    int n;
    lv = '{1, 1, 2, 3, 4};
    rstn = 1'b0;
    din5 = '0;
    for (int i = 0; i < 3; i++) din[i] = '0;
    for (int i = 0; i < 4; i++) wr[i] = 1'b0;
    repeat (3) @(negedge clk_50m);
    chk("rst_tx", tx[0], 1);
    chk("rst_busy", busy[0], 0);
    chk("rst_empty", empty[0], 1);
    chk("rst_full", full[0], 0);
    chk("rst_level", lvl[0], 0);
    chk("rst_ovf", ovf[0], 0);
    rstn = 1'b1;
    tick_en = 1'b1;
    @(negedge clk_50m);

    expect_frame(0, 10, 16'b0101001011, 1'b0);
    wrw(0, 8'hA5);
    chk("a5_level", lvl[0], 1);
    chk("a5_busy_pre", busy[0], 0);
    @(negedge clk_50m);
    chk("a5_busy_pop", busy[0], 1);
    chk("a5_level_pop", lvl[0], 0);
    chk("a5_empty_pop", empty[0], 1);
    drain();
    chk("a5_busy_end", busy[0], 0);
    chk("a5_tx_end", tx[0], 1);

    tick_en = 1'b0;
    repeat (2) @(negedge clk_50m);
    for (int i = 0; i < 5; i++) begin
      wrw(0, 8'h11 + 8'(i));
      chk("fifo_level", lvl[0], lv[i]);
      chk("fifo_full", full[0], (i == 4) ? 1 : 0);
    end
    chk("fifo_ovf_clear", ovf[0], 0);
    wrw(0, 8'h16);
    chk("fifo_ovf_set", ovf[0], 1);
    chk("fifo_level_held", lvl[0], 4);
    @(negedge clk_50m);
    chk("fifo_ovf_sticky", ovf[0], 1);
    expect_frame(0, 10, 16'b0100010001, 1'b0);
    expect_frame(0, 10, 16'b0010010001, 1'b1);
    expect_frame(0, 10, 16'b0110010001, 1'b1);
    expect_frame(0, 10, 16'b0001010001, 1'b1);
    expect_frame(0, 10, 16'b0101010001, 1'b1);
    tick_en = 1'b1;
    drain();
    chk("fifo_empty_end", empty[0], 1);
    chk("fifo_ovf_end", ovf[0], 1);

    wrw(0, 8'h52);
    wrw(0, 8'h99);
    n = 0;
    while (!busy[0] && n < 50) begin
      @(negedge clk_50m);
      n++;
    end
    repeat (5) wait_tick();
    repeat (3) @(negedge clk_50m);
    chk("mid_tx_bit3", tx[0], 0);
    chk("mid_busy", busy[0], 1);
    chk("mid_level", lvl[0], 1);
    rstn = 1'b0;
    @(negedge clk_50m);
    chk("mrst_tx", tx[0], 1);
    chk("mrst_busy", busy[0], 0);
    chk("mrst_level", lvl[0], 0);
    chk("mrst_ovf", ovf[0], 0);
    chk("mrst_empty", empty[0], 1);
    rstn = 1'b1;
    @(negedge clk_50m);
    expect_frame(0, 10, 16'b0110000111, 1'b0);
    wrw(0, 8'hC3);
    drain();

    expect_frame(1, 12, 16'b011000000011, 1'b0);
    wrw(1, 8'h03);
    drain();
    expect_frame(2, 12, 16'b011000000111, 1'b0);
    wrw(2, 8'h03);
    drain();

    expect_frame(3, 7, 16'b0111111, 1'b0);
    wrw(3, 8'h1F);
    drain();

    tick_en = 1'b0;
    repeat (2) @(negedge clk_50m);
    wrw(0, 8'h81);
    chk("sim_level_1", lvl[0], 1);
    wrw(0, 8'h7E);
    chk("sim_level_wp", lvl[0], 1);
    chk("sim_busy", busy[0], 1);
    expect_frame(0, 10, 16'b0100000011, 1'b0);
    expect_frame(0, 10, 16'b0011111101, 1'b1);
    tick_en = 1'b1;
    drain();
    chk("sim_empty_end", empty[0], 1);

    repeat (4) @(negedge clk_50m);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
